// File: rtl/tag_pkg.sv
// Shared record layout and decoded-record type for the tagger record decoder.
package tag_pkg;

  localparam int TS_LSB   = 0;
  localparam int TS_W     = 36;
  localparam int CH_LSB   = 36;
  localparam int CH_W     = 4;
  localparam int TYPE_BIT = 45;
  localparam int WRAP_BIT = 46;
  localparam int REC_W    = 47;

  localparam logic TYPE_STROBE = 1'b0;
  localparam logic TYPE_DELTA  = 1'b1;

  // Everything of a decoded record except the epoch, whose width is a parameter.
  typedef struct packed {
    logic [TS_W-1:0] timer;
    logic [CH_W-1:0] chan;
    logic            rtype;
    logic [CH_W-1:0] changed;
  } dec_fields_t;

  function automatic logic is_bare(input logic rtype, input logic [CH_W-1:0] chan);
    return (rtype == TYPE_STROBE) && (chan == '0);
  endfunction

endpackage

// File: rtl/tag_record_decoder_if.sv
// Record input strobe and decoded-record readout handshake of the tag decoder.
interface tag_record_decoder_if
  import tag_pkg::*;
#(
  parameter int EPOCH_W = 28
);

  logic [REC_W-1:0]        in_data;
  logic                    in_ready;
  logic                    out_valid;
  logic                    out_ack;
  logic [EPOCH_W+TS_W-1:0] out_time;
  logic [CH_W-1:0]         out_chan;
  logic                    out_type;
  logic [CH_W-1:0]         out_changed;

  modport master (
    output in_data, in_ready, out_ack,
    input  out_valid, out_time, out_chan, out_type, out_changed
  );

  modport slave (
    input  in_data, in_ready, out_ack,
    output out_valid, out_time, out_chan, out_type, out_changed
  );

endinterface

// File: rtl/tag_fifo.sv
// Synchronous FIFO with a registered head: a write is visible on the second edge
// after it, and a write is accepted while full only when the head pops that cycle.
module tag_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic         rd_valid,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty,
  output logic         wr_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   s_cnt;
  logic [AW:0]   total;
  logic          pop;
  logic          push;
  logic          load;

  // Occupancy counts the head register as well as the storage behind it.
  assign total   = s_cnt + {{AW{1'b0}}, rd_valid};
  assign full    = (total == FULL_CNT);
  assign empty   = (total == '0);
  assign pop     = rd_valid & rd_en;
  assign push    = wr_en & (~full | pop);
  assign wr_drop = wr_en & full & ~pop;
  assign load    = (s_cnt != '0) & (~rd_valid | pop);

  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      s_cnt    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      s_cnt    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (load) begin
        rd_ptr   <= rd_ptr + 1'b1;
        rd_data  <= mem[rd_ptr];
        rd_valid <= 1'b1;
      end else if (pop) begin
        rd_valid <= 1'b0;
      end
      case ({push, load})
        2'b10:   s_cnt <= s_cnt + 1'b1;
        2'b01:   s_cnt <= s_cnt - 1'b1;
        default: s_cnt <= s_cnt;
      endcase
    end
  end

endmodule

// File: rtl/tag_record_decoder.sv
// Tagger record decoder: validates records, extends the timer with a wrap-counted
// epoch, tracks delta levels and queues decoded records for the readout handshake.
module tag_record_decoder
  import tag_pkg::*;
#(
  parameter int EPOCH_W   = 28,
  parameter int DEPTH     = 16,
  parameter int PASS_WRAP = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  tag_record_decoder_if.slave bus,
  output logic                overflow,
  output logic [15:0]         drop_count
);

  localparam int FIELD_W = $bits(dec_fields_t);
  localparam int FIFO_W  = EPOCH_W + FIELD_W;

  logic [TS_W-1:0]    in_timer;
  logic [CH_W-1:0]    in_chan;
  logic               in_type;
  logic               in_wrap;
  logic               keep;
  logic [EPOCH_W-1:0] epoch;
  logic [EPOCH_W-1:0] epoch_nxt;
  logic [CH_W-1:0]    delta_lvl;
  dec_fields_t        dec;

  logic               s1_valid;
  logic [EPOCH_W-1:0] s1_epoch;
  dec_fields_t        s1_fields;

  logic               fifo_wr_en;
  logic               fifo_drop;
  logic               fifo_rd_valid;
  logic [FIFO_W-1:0]  fifo_rd_data;
  dec_fields_t        head_fields;
  logic               unused_full;
  logic               unused_empty;
  logic               unused_bits;

  assign in_timer    = bus.in_data[TS_LSB +: TS_W];
  assign in_chan     = bus.in_data[CH_LSB +: CH_W];
  assign in_type     = bus.in_data[TYPE_BIT];
  assign in_wrap     = bus.in_data[WRAP_BIT];
  assign unused_bits = ^bus.in_data[TYPE_BIT-1:CH_LSB+CH_W];

  // Bare wraps only carry the epoch; a strobe with no channels and no wrap is junk.
  assign keep      = !is_bare(in_type, in_chan) || (in_wrap && (PASS_WRAP != 0));
  assign epoch_nxt = epoch + {{(EPOCH_W-1){1'b0}}, in_wrap};

  always_comb begin
    dec         = '0;
    dec.timer   = in_timer;
    dec.chan    = in_chan;
    dec.rtype   = in_type;
    if (in_type == TYPE_DELTA) begin
      dec.changed = in_chan ^ delta_lvl;
    end
  end

  // Epoch and delta level advance even for records later dropped on overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      epoch     <= '0;
      delta_lvl <= '0;
      s1_valid  <= 1'b0;
      s1_epoch  <= '0;
      s1_fields <= '0;
    end else if (clear) begin
      epoch     <= '0;
      delta_lvl <= '0;
      s1_valid  <= 1'b0;
      s1_epoch  <= '0;
      s1_fields <= '0;
    end else begin
      s1_valid <= bus.in_ready & keep;
      if (bus.in_ready) begin
        epoch     <= epoch_nxt;
        s1_epoch  <= epoch_nxt;
        s1_fields <= dec;
        if (in_type == TYPE_DELTA) begin
          delta_lvl <= in_chan;
        end
      end
    end
  end

  assign fifo_wr_en = s1_valid & ~clear;

  tag_fifo #(
    .W     (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (reset),
    .clear    (clear),
    .wr_en    (fifo_wr_en),
    .wr_data  ({s1_epoch, s1_fields}),
    .rd_en    (bus.out_ack),
    .rd_valid (fifo_rd_valid),
    .rd_data  (fifo_rd_data),
    .full     (unused_full),
    .empty    (unused_empty),
    .wr_drop  (fifo_drop)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (fifo_drop) begin
      overflow <= 1'b1;
      if (drop_count != 16'hFFFF) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end

  assign head_fields     = dec_fields_t'(fifo_rd_data[FIELD_W-1:0]);
  assign bus.out_valid   = fifo_rd_valid;
  assign bus.out_time    = {fifo_rd_data[FIFO_W-1 -: EPOCH_W], head_fields.timer};
  assign bus.out_chan    = head_fields.chan;
  assign bus.out_type    = head_fields.rtype;
  assign bus.out_changed = head_fields.changed;

endmodule

// File: tb/tb_tag_record_decoder.sv
// Bench for tag_record_decoder: two instances (wide epoch with wraps consumed, 4-bit
// epoch with wraps passed) driven in lockstep and compared against a queue model.
module tb_tag_record_decoder;

  logic        clk;
  logic        reset;
  logic        clear;
  logic        ovf0, ovf1;
  logic [15:0] dc0, dc1;

  tag_record_decoder_if #(.EPOCH_W(28)) bus0 ();
  tag_record_decoder_if #(.EPOCH_W(4))  bus1 ();

  tag_record_decoder #(.EPOCH_W(28), .DEPTH(16), .PASS_WRAP(0)) dut0 (
    .clk(clk), .reset(reset), .clear(clear), .bus(bus0.slave),
    .overflow(ovf0), .drop_count(dc0)
  );

  tag_record_decoder #(.EPOCH_W(4), .DEPTH(16), .PASS_WRAP(1)) dut1 (
    .clk(clk), .reset(reset), .clear(clear), .bus(bus1.slave),
    .overflow(ovf1), .drop_count(dc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] t;
    logic [3:0]  ch;
    logic        ty;
    logic [3:0]  chg;
    int          w;
  } mrec_t;

  mrec_t       mq [2][$];
  logic [63:0] m_epoch [2];
  logic [3:0]  m_delta [2];
  bit          m_s1v [2];
  mrec_t       m_s1 [2];
  bit          m_vis [2];
  bit          m_ovf [2];
  int          m_drops [2];
  int          edge_n;
  int          n_total;
  int          n_bad;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [46:0] rec(input bit wrap, input bit ty, input logic [3:0] ch,
                                      input logic [35:0] t);
    return {wrap, ty, 5'b0, ch, t};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      m_epoch[i] = '0;
      m_delta[i] = '0;
      m_s1v[i]   = 1'b0;
      m_vis[i]   = 1'b0;
      m_ovf[i]   = 1'b0;
      m_drops[i] = 0;
    end
  endtask

  // One clock edge of behaviour for instance i, given the inputs present at that edge.
  task automatic model_step(input int i, input bit rdy, input logic [46:0] din,
                            input bit ack, input bit clr);
    bit          pop;
    int          pre_n;
    mrec_t       r;
    logic [63:0] mask;
    logic [3:0]  ch;
    mask = (i == 0) ? ((64'd1 << 28) - 1) : 64'hF;
    if (clr) begin
      mq[i].delete();
      m_epoch[i] = '0;
      m_delta[i] = '0;
      m_s1v[i]   = 1'b0;
      m_vis[i]   = 1'b0;
      return;
    end
    pop   = m_vis[i] && ack;
    pre_n = mq[i].size();
    if (pop) void'(mq[i].pop_front());
    if (m_s1v[i]) begin
      if (pre_n == 16 && !pop) begin
        m_ovf[i] = 1'b1;
        if (m_drops[i] < 65535) m_drops[i]++;
      end else begin
        r   = m_s1[i];
        r.w = edge_n;
        mq[i].push_back(r);
      end
    end
    m_s1v[i] = 1'b0;
    if (rdy) begin
      ch = din[39:36];
      if (din[46]) m_epoch[i] = (m_epoch[i] + 64'd1) & mask;
      r.t   = (m_epoch[i] << 36) | {28'd0, din[35:0]};
      r.ch  = ch;
      r.ty  = din[45];
      r.chg = din[45] ? (ch ^ m_delta[i]) : 4'd0;
      r.w   = 0;
      if (din[45]) m_delta[i] = ch;
      if (din[45] || ch != 4'd0 || (din[46] && i == 1)) begin
        m_s1v[i] = 1'b1;
        m_s1[i]  = r;
      end
    end
    m_vis[i] = (mq[i].size() > 0) && (mq[i][0].w < edge_n);
  endtask

  task automatic compare(input int i);
    logic        v, ty, ov;
    logic [63:0] t;
    logic [3:0]  ch, chg;
    logic [15:0] dc;
    if (i == 0) begin
      v = bus0.out_valid; t = 64'(bus0.out_time); ch = bus0.out_chan;
      ty = bus0.out_type; chg = bus0.out_changed; ov = ovf0; dc = dc0;
    end else begin
      v = bus1.out_valid; t = 64'(bus1.out_time); ch = bus1.out_chan;
      ty = bus1.out_type; chg = bus1.out_changed; ov = ovf1; dc = dc1;
    end
    chk($sformatf("u%0d.valid@%0d", i, edge_n), 64'(v), 64'(m_vis[i]));
    chk($sformatf("u%0d.overflow@%0d", i, edge_n), 64'(ov), 64'(m_ovf[i]));
    chk($sformatf("u%0d.drop_count@%0d", i, edge_n), 64'(dc), 64'(m_drops[i]));
    if (m_vis[i] && v) begin
      chk($sformatf("u%0d.time@%0d", i, edge_n), t, mq[i][0].t);
      chk($sformatf("u%0d.chan@%0d", i, edge_n), 64'(ch), 64'(mq[i][0].ch));
      chk($sformatf("u%0d.type@%0d", i, edge_n), 64'(ty), 64'(mq[i][0].ty));
      chk($sformatf("u%0d.changed@%0d", i, edge_n), 64'(chg), 64'(mq[i][0].chg));
    end
  endtask

  task automatic cyc(input bit rdy, input logic [46:0] d, input bit ack, input bit clr);
    logic [63:0] g;
    logic [46:0] dv;
    g  = {$urandom(), $urandom()};
    dv = rdy ? d : g[46:0];
    bus0.in_ready = rdy; bus1.in_ready = rdy;
    bus0.in_data  = dv;  bus1.in_data  = dv;
    bus0.out_ack  = ack; bus1.out_ack  = ack;
    clear = clr;
    @(posedge clk);
    edge_n++;
    model_step(0, rdy, dv, ack, clr);
    model_step(1, rdy, dv, ack, clr);
    #1;
    compare(0);
    compare(1);
  endtask

  task automatic idle(input int n, input bit ack);
    for (int k = 0; k < n; k++) cyc(1'b0, '0, ack, 1'b0);
  endtask

  initial begin
    logic [3:0] ch;
    int         ack_pct;
    n_total = 0;
    n_bad   = 0;
    edge_n  = 0;
    reset   = 1'b1;
    clear   = 1'b0;
    bus0.in_ready = 1'b0; bus1.in_ready = 1'b0;
    bus0.in_data  = '0;   bus1.in_data  = '0;
    bus0.out_ack  = 1'b0; bus1.out_ack  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.valid", 64'(bus0.out_valid), 64'd0);
    chk("reset.time", 64'(bus0.out_time), 64'd0);
    chk("reset.chan", 64'(bus0.out_chan), 64'd0);
    chk("reset.overflow", 64'(ovf0), 64'd0);
    chk("reset.drop_count", 64'(dc0), 64'd0);
    reset = 1'b0;

    // first strobe: two-cycle latency to out_valid
    cyc(1'b1, rec(0, 0, 4'b0101, 36'h123), 1'b0, 1'b0);
    idle(1, 1'b0);
    chk("lat.valid_early", 64'(bus0.out_valid), 64'd0);
    idle(1, 1'b0);
    chk("lat.valid", 64'(bus0.out_valid), 64'd1);
    chk("lat.time", 64'(bus0.out_time), 64'h123);
    chk("lat.chan", 64'(bus0.out_chan), 64'b0101);
    chk("lat.changed", 64'(bus0.out_changed), 64'd0);
    idle(4, 1'b1);

    // bare wrap then strobe
    cyc(1'b1, rec(1, 0, 4'b0000, 36'd0), 1'b0, 1'b0);
    cyc(1'b1, rec(0, 0, 4'b0001, 36'd5), 1'b0, 1'b0);
    idle(2, 1'b0);
    chk("wrap.time", 64'(bus0.out_time), {28'd1, 36'd5});
    chk("wrap.pass_time", 64'(bus1.out_time), {4'd1, 36'd0});
    idle(6, 1'b1);

    // delta levels
    cyc(1'b1, rec(0, 1, 4'b0011, 36'd10), 1'b0, 1'b0);
    cyc(1'b1, rec(0, 1, 4'b0110, 36'd11), 1'b0, 1'b0);
    idle(2, 1'b0);
    chk("delta.first_changed", 64'(bus0.out_changed), 64'b0011);
    idle(1, 1'b1);
    chk("delta.second_changed", 64'(bus0.out_changed), 64'b0101);
    idle(4, 1'b1);

    // overflow: 17 strobes with no acks
    for (int k = 0; k < 17; k++)
      cyc(1'b1, rec(0, 0, 4'(1 + (k % 15)), 36'(100 + k)), 1'b0, 1'b0);
    idle(2, 1'b0);
    chk("full.drop_count", 64'(dc0), 64'd1);
    chk("full.overflow", 64'(ovf0), 64'd1);
    cyc(1'b1, rec(1, 0, 4'b0010, 36'd200), 1'b0, 1'b0);
    idle(2, 1'b0);
    chk("full.wrap_dropped", 64'(dc0), 64'd2);
    // write lands on the same edge as a pop while full
    cyc(1'b1, rec(0, 0, 4'b1000, 36'd300), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("full.simul_nodrop", 64'(dc0), 64'd2);
    idle(20, 1'b1);

    // clear with a wrap record on the same edge
    for (int k = 0; k < 3; k++) cyc(1'b1, rec(1, 0, 4'b0000, 36'd0), 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) cyc(1'b1, rec(0, 0, 4'b0100, 36'(400 + k)), 1'b0, 1'b0);
    idle(2, 1'b0);
    cyc(1'b1, rec(1, 0, 4'b0000, 36'd0), 1'b0, 1'b1);
    chk("clear.valid", 64'(bus0.out_valid), 64'd0);
    chk("clear.drop_count", 64'(dc0), 64'd2);
    cyc(1'b1, rec(0, 0, 4'b0001, 36'd7), 1'b0, 1'b0);
    idle(2, 1'b0);
    chk("clear.epoch_zero", 64'(bus0.out_time), 64'd7);
    idle(3, 1'b1);

    // randomized traffic with varying backpressure
    ack_pct = 50;
    for (int k = 0; k < 3000; k++) begin
      if (k % 250 == 0) ack_pct = (k % 750 == 0) ? 10 : ((k % 500 == 0) ? 95 : 50);
      ch = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      cyc($urandom_range(0, 9) < 6,
          rec($urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)), ch,
              36'({$urandom(), $urandom()})),
          $urandom_range(0, 99) < ack_pct,
          $urandom_range(0, 299) == 0);
    end

    // reset in the middle of a burst
    for (int k = 0; k < 6; k++) cyc(1'b1, rec(0, 0, 4'b1111, 36'(500 + k)), 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst.valid", 64'(bus0.out_valid), 64'd0);
    chk("midrst.time", 64'(bus0.out_time), 64'd0);
    chk("midrst.overflow", 64'(ovf0), 64'd0);
    chk("midrst.drop_count", 64'(dc0), 64'd0);
    chk("midrst.u1_valid", 64'(bus1.out_valid), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 40; k++)
      cyc($urandom_range(0, 1) == 1, rec(0, 1, 4'($urandom_range(0, 15)), 36'(k)),
          $urandom_range(0, 1) == 1, 1'b0);
    idle(20, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/tag_record_decoder.md
Name: tag_record_decoder

Overview:
- Receiving end of the 47-bit tagger record stream (data/ready strobe from the pulse tagger, same clock domain).
- Validates and decodes each record, extends the 36-bit timer to a full absolute timestamp by counting wraparound records, and tracks delta-channel state.
- Buffers decoded records in a small FIFO; presents them to the USB/readout path on a valid/ready handshake.

Parameters:
- EPOCH_W, 28, width of the wraparound (epoch) counter; output timestamp width is EPOCH_W+36.
- DEPTH, 16, FIFO entries; power of two, at least 4.
- PASS_WRAP, 0, 1 = emit bare wrap records (strobe type, channels 0); 0 = consume them silently.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- clear  in  1  synchronous: zero the epoch counter and delta state, flush the FIFO
- in_data  in  47  tagger record: [35:0] timer, [39:36] channels, [44:40] unused, [45] type (1=delta, 0=strobe), [46] wrap flag
- in_ready  in  1  in_data is valid this cycle; in_data is don't-care (may be Z) when low
- out_valid  out  1  output record available
- out_ack  in  1  downstream accepts the head record when out_valid is also high
- out_time  out  EPOCH_W+36  {epoch, timer}
- out_chan  out  4  strobe channels, or new delta level
- out_type  out  1  copy of the record type bit
- out_changed  out  4  delta records: new XOR previous delta level; strobe records: 0
- overflow  out  1  sticky; set on any dropped record
- drop_count  out  16  saturating count of dropped records

Behaviour:
- Reset values: out_valid=0, all data outputs=0, overflow=0, drop_count=0, epoch=0, delta state=0, FIFO empty.
- Stage 1: on a clk edge with in_ready=1, register the decoded record.
  - If bit 46=1, epoch increments (modulo 2^EPOCH_W) and the record uses the incremented epoch.
  - Delta record: delta state <= in_data[39:36]; out_changed = in_data[39:36] XOR old state.
- Stage 2: FIFO write on the following edge.
  - out_valid rises on the edge after the write, giving 2-cycle latency from input edge to out_valid when the FIFO is empty.
- Epoch and delta state update on every in_ready record, including records dropped for overflow, so timestamps stay correct after a drop.
- Bare wrap record (type 0, channels 0, bit 46=1) with PASS_WRAP=0: epoch updates; nothing is written to the FIFO.
- Record with type 0, channels 0, bit 46=0: malformed. Discard it; it is not counted as a drop.
- Handshake: the head record pops on an edge where out_valid and out_ack are both 1.
  - Outputs are held stable while out_valid=1 and out_ack=0.
  - Back-to-back pops are allowed, one per cycle.
- Full FIFO:
  - A write with no pop in the same cycle is dropped: overflow <= 1, drop_count += 1, saturating at 16'hFFFF.
  - A simultaneous write and pop while full: both succeed and occupancy is unchanged.
- Empty FIFO: out_ack is ignored.
- A stage-1 record and a pop in the same cycle are independent.
- clear:
  - Takes priority over in_ready in the same cycle: the record is discarded and the epoch goes to 0, not 1.
  - Also flushes the stage-1 register.
  - Does not clear overflow or drop_count; only reset clears those.
- Reset mid-stream: immediate return to reset values; any record in flight is lost.
- Epoch wrap at 2^EPOCH_W-1 to 0 is silent.

Decomposition:
- Shared package tag_pkg holds:
  - record field offsets: TS_LSB=0, TS_W=36, CH_LSB=36, TYPE_BIT=45, WRAP_BIT=46, REC_W=47;
  - the TYPE_STROBE and TYPE_DELTA constants;
  - a struct/typedef for the decoded record.
- One sub-module, tag_fifo: synchronous FIFO with parameterised width and depth, full/empty flags, and same-cycle read/write when full. The decoder top holds the decode, epoch and delta logic plus the counters.

Test Plan:
- Reset, then strobe record timer=0x000000123, ch=4'b0101, wrap=0, type=0 -> out_valid 2 cycles later; out_time=0x123, out_chan=0101, out_changed=0.
- Bare wrap (bit46=1, ch=0) followed by strobe timer=5, ch=0001 -> no output for the wrap; strobe emitted with out_time={28'd1, 36'd5}. Repeat with PASS_WRAP=1 -> wrap emitted with epoch 1, timer 0.
- Delta records with channel levels 0011 then 0110 -> out_changed=0011, then 0101; out_type=1 on both.
- out_ack held low, 17 strobe records with DEPTH=16 -> 16 stored, overflow=1, drop_count=1. Then a wrap record while full -> dropped, but the epoch still increments (next emitted record shows epoch+1).
- Full FIFO, in_ready and out_ack asserted on the same edge -> no drop; occupancy stays at 16; record order preserved.
- clear asserted together with a wrap record after epoch=3 -> epoch=0, FIFO empty, out_valid=0, drop_count unchanged. Asynchronous reset asserted mid-burst -> all outputs return to 0 immediately.
